// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use/branch/memory-wait stalls and flushes.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic [4:0] Rd_M,
    input  logic [4:0] Rd_W,
    input  logic [1:0] ResultSrc_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       PCSrc_E,
    input  logic       MemReq_M,
    input  logic       MemReady,
    output logic       StallF,
    output logic       EnD,
    output logic       FlushD,
    output logic       EnE,
    output logic       FlushE,
    output logic       EnM,
    output logic       FlushW,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       MemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
    output logic [15:0] TmoCnt
`endif
);

    typedef enum logic {S_RUN, S_WAIT} state_e;

    state_e             state_q;
    logic [TMO_W-1:0]   count_q;
    logic               tmo_q;

    logic mem_pending;
    logic tmo_release;
    logic tmo_fire;
    logic mem_stall;
    logic lw_stall;

    // MEM result wins over WB because it is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 5'd0 && Rd_M == rs)
            return 2'b10;
        else if (RegWrite_W && Rd_W != 5'd0 && Rd_W == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mem_pending = MemReq_M && !MemReady;
    assign tmo_release = (state_q == S_WAIT) && (count_q == TMO_W'(MEM_TIMEOUT - 1));
    // A fire is the release cycle that actually abandons the access (still requested, not ready).
    assign tmo_fire    = tmo_release && mem_pending;
    assign mem_stall   = mem_pending && !tmo_release;
    assign lw_stall    = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                         ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    assign MemTimeout  = tmo_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        StallF     = 1'b0;
        EnD        = 1'b1;
        FlushD     = 1'b0;
        EnE        = 1'b1;
        FlushE     = 1'b0;
        EnM        = 1'b1;
        FlushW     = tmo_fire;
        ForwardA_E = fwd_sel(Rs1_E);
        ForwardB_E = fwd_sel(Rs2_E);
        if (rst) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            FlushW     = 1'b1;
            ForwardA_E = 2'b00;
            ForwardB_E = 2'b00;
        end else if (mem_stall) begin
            StallF = 1'b1;
            EnD    = 1'b0;
            EnE    = 1'b0;
            EnM    = 1'b0;
            FlushW = 1'b1;
        end else if (PCSrc_E) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            EnD    = 1'b0;
            FlushE = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            count_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mem_pending) begin
                        state_q <= S_WAIT;
                        count_q <= TMO_W'(1);
                    end
                end
                S_WAIT: begin
                    if (MemReady || !MemReq_M) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                    end else if (tmo_release) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                        tmo_q   <= 1'b1;
                    end else if (count_q != '1) begin
                        count_q <= count_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    count_q <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            if (StallF && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushE && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (tmo_fire && tmo_cnt_q != '1)
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign TmoCnt   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic [1:0] ResultSrc_E;
    logic       RegWrite_M, RegWrite_W, PCSrc_E, MemReq_M, MemReady;
    logic       StallF, EnD, FlushD, EnE, FlushE, EnM, FlushW, MemTimeout;
    logic [1:0] ForwardA_E, ForwardB_E;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
    logic [15:0] TmoCnt;
`endif

    hazard_ctrl #(.TMO_W(8), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .ResultSrc_E(ResultSrc_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .MemReady(MemReady),
        .StallF(StallF), .EnD(EnD), .FlushD(FlushD), .EnE(EnE), .FlushE(FlushE),
        .EnM(EnM), .FlushW(FlushW), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .TmoCnt(TmoCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: how many consecutive cycles the current access has already stalled.
    int   stalled_for = 0;
    logic tmo_m = 1'b0;
    longint stall_m = 0, flush_m = 0, tmocnt_m = 0;

    // Expectations of the current cycle, kept for the model update.
    logic e_stallf, e_end, e_flushd, e_ene, e_flushe, e_enm, e_flushw, e_fire;
    logic [1:0] e_fa, e_fb;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic settle();
        logic pending, lw;
        #1;
        pending = MemReq_M && !MemReady;
        e_fire  = pending && (stalled_for == TMO - 1);
        lw      = (ResultSrc_E == 2'b01) && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
        e_fa = ref_fwd(Rs1_E);
        e_fb = ref_fwd(Rs2_E);
        {e_stallf, e_end, e_flushd, e_ene, e_flushe, e_enm, e_flushw} = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, e_fire};
        if (rst) begin
            {e_flushd, e_flushe, e_flushw} = 3'b111;
            e_fa = 2'b00;
            e_fb = 2'b00;
        end else if (pending && !e_fire) begin
            {e_stallf, e_end, e_flushd, e_ene, e_flushe, e_enm, e_flushw} = 7'b1000001;
        end else if (PCSrc_E) begin
            {e_flushd, e_flushe} = 2'b11;
        end else if (lw) begin
            {e_stallf, e_end, e_flushe} = 3'b101;
        end
        check("StallF", 32'(StallF), 32'(e_stallf));
        check("EnD", 32'(EnD), 32'(e_end));
        check("FlushD", 32'(FlushD), 32'(e_flushd));
        check("EnE", 32'(EnE), 32'(e_ene));
        check("FlushE", 32'(FlushE), 32'(e_flushe));
        check("EnM", 32'(EnM), 32'(e_enm));
        check("FlushW", 32'(FlushW), 32'(e_flushw));
        check("ForwardA_E", 32'(ForwardA_E), 32'(e_fa));
        check("ForwardB_E", 32'(ForwardB_E), 32'(e_fb));
        check("MemTimeout", 32'(MemTimeout), 32'(tmo_m));
`ifdef HAZARD_PERF_EN
        check("StallCnt", StallCnt, 32'(stall_m));
        check("FlushCnt", FlushCnt, 32'(flush_m));
        check("TmoCnt", 32'(TmoCnt), 32'(tmocnt_m));
`endif
    endtask

    task automatic advance();
        if (rst) begin
            stalled_for = 0;
            tmo_m       = 1'b0;
            stall_m     = 0;
            flush_m     = 0;
            tmocnt_m    = 0;
        end else begin
            if (e_stallf && stall_m < 64'hFFFF_FFFF) stall_m++;
            if (e_flushe && flush_m < 64'hFFFF_FFFF) flush_m++;
            if (e_fire && tmocnt_m < 64'hFFFF) tmocnt_m++;
            if (e_fire) begin
                tmo_m       = 1'b1;
                stalled_for = 0;
            end else if (MemReq_M && !MemReady) begin
                stalled_for++;
            end else begin
                stalled_for = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
        ResultSrc_E = 2'b00;
        {RegWrite_M, RegWrite_W, PCSrc_E, MemReq_M, MemReady} = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        settle();
        check("rst_flushes", 32'({FlushD, FlushE, FlushW, StallF}), 32'b1110);
        advance();
        rst = 1'b0;

        // Two load-use stalls and one branch redirect.
        ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
        settle(); check("lw_stall", 32'({StallF, EnD, FlushE}), 32'b101); advance();
        settle(); advance();
        PCSrc_E = 1'b1;
        settle(); check("br_over_lw", 32'({FlushD, FlushE, StallF, EnD}), 32'b1101); advance();
        idle_inputs();
        settle();
`ifdef HAZARD_PERF_EN
        check("perf_stall2", StallCnt, 32'd2);
        check("perf_flush3", FlushCnt, 32'd3);
`endif
        advance();

        ResultSrc_E = 2'b01; Rd_E = 5'd0; Rs2_D = 5'd0;
        settle(); check("lw_rd0", 32'(StallF), 32'd0); advance();

        idle_inputs();
        Rd_M = 5'd5; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1; Rs1_E = 5'd5;
        settle(); check("fwd_mem", 32'({ForwardA_E, ForwardB_E}), 32'b1000); advance();
        Rd_M = 5'd0;
        settle(); check("fwd_wb", 32'(ForwardA_E), 32'b01); advance();

        // Memory wait of three cycles, then ready.
        idle_inputs();
        MemReq_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); check("mem_wait", 32'({StallF, EnD, EnE, EnM, FlushW}), 32'b10001); advance();
        end
        MemReady = 1'b1;
        settle(); check("mem_done", 32'({StallF, FlushW, MemTimeout}), 32'b000); advance();
        MemReady = 1'b0; MemReq_M = 1'b0;
        settle(); advance();

        // Watchdog: ready never arrives.
        MemReq_M = 1'b1;
        for (int i = 0; i < TMO - 1; i++) begin
            settle(); check("tmo_wait", 32'(StallF), 32'd1); advance();
        end
        settle(); check("tmo_release", 32'({StallF, EnM, FlushW}), 32'b011); advance();
        MemReq_M = 1'b0;
        settle(); check("tmo_sticky", 32'(MemTimeout), 32'd1); advance();
        rst = 1'b1;
        settle(); advance();
        settle(); check("rst_clears_tmo", 32'({MemTimeout, FlushD, FlushE, FlushW}), 32'b0111); advance();

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            Rs1_D       = 5'($urandom_range(0, 3));
            Rs2_D       = 5'($urandom_range(0, 3));
            Rs1_E       = 5'($urandom_range(0, 3));
            Rs2_E       = 5'($urandom_range(0, 3));
            Rd_E        = 5'($urandom_range(0, 3));
            Rd_M        = 5'($urandom_range(0, 3));
            Rd_W        = 5'($urandom_range(0, 3));
            ResultSrc_E = 2'($urandom_range(0, 3));
            RegWrite_M  = 1'($urandom_range(0, 1));
            RegWrite_W  = 1'($urandom_range(0, 1));
            PCSrc_E     = ($urandom_range(0, 7) == 0);
            MemReq_M    = ($urandom_range(0, 3) != 0);
            MemReady    = ($urandom_range(0, 3) == 0);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control end of the pipeline registers: generates every `en`/`flush` pair driven into the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the EX-stage forwarding selects.
- Detects load-use hazards, taken-branch redirects and variable-latency data-memory waits.
- Contains a memory-wait FSM with a timeout watchdog.
- Sits beside the datapath and consumes register indices and control bits from ID, EX, MEM and WB.

Parameters:
- TMO_W, 8, width of the memory-wait counter.
- MEM_TIMEOUT, 200, wait cycles before the watchdog fires; legal range 2 to 2^TMO_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Rs1_D  in  5  rs1 of instruction in ID
- Rs2_D  in  5  rs2 of instruction in ID
- Rs1_E  in  5  rs1 of instruction in EX
- Rs2_E  in  5  rs2 of instruction in EX
- Rd_E  in  5  rd in EX
- Rd_M  in  5  rd in MEM
- Rd_W  in  5  rd in WB
- ResultSrc_E  in  2  EX result select; 2'b01 = load
- RegWrite_M  in  1  MEM writes the register file
- RegWrite_W  in  1  WB writes the register file
- PCSrc_E  in  1  taken branch/jump resolved in EX
- MemReq_M  in  1  load/store active in MEM
- MemReady  in  1  data memory completes this cycle
- StallF  out  1  hold PC
- EnD  out  1  IF/ID enable
- FlushD  out  1  IF/ID flush
- EnE  out  1  ID/EX enable
- FlushE  out  1  ID/EX flush
- EnM  out  1  EX/MEM enable
- FlushW  out  1  MEM/WB flush (bubble)
- ForwardA_E  out  2  SrcA select: 00 RF, 01 WB result, 10 MEM ALU result
- ForwardB_E  out  2  SrcB select, same encoding
- MemTimeout  out  1  sticky watchdog error

Behaviour:
- Reset:
  - Synchronous and active-high.
  - While `rst`=1: StallF=0, EnD=EnE=EnM=1, FlushD=FlushE=FlushW=1, ForwardA_E=ForwardB_E=00.
  - FSM goes to RUN, counter is cleared to 0, MemTimeout is cleared to 0.
  - All other outputs are combinational from current state and inputs.
- Forwarding, per operand X in {1,2}:
  - 10 if RegWrite_M && Rd_M!=0 && Rd_M==RsX_E.
  - Else 01 if RegWrite_W && Rd_W!=0 && Rd_W==RsX_E.
  - Else 00.
  - MEM has priority over WB.
- Load-use detection:
  - lwStall = (ResultSrc_E==01) && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D).
- Memory stall:
  - memStall = MemReq_M && !MemReady && !tmoRelease.
  - tmoRelease = state==WAIT && count==MEM_TIMEOUT-1.
- Output priority, first match wins:
  1. memStall: StallF=1, EnD=EnE=EnM=0, FlushD=FlushE=0, FlushW=1. Branch and load-use are ignored this cycle; EX is frozen, so they re-evaluate after release.
  2. PCSrc_E: FlushD=FlushE=1, StallF=0, all enables 1. lwStall is suppressed.
  3. lwStall: StallF=1, EnD=0, FlushE=1, EnE=EnM=1.
  4. Otherwise: no stall, no flush, all enables 1.
- FSM:
  - RUN: if MemReq_M && !MemReady, go to WAIT with count=1; else stay.
  - WAIT, MemReady=1: go to RUN, count=0.
  - WAIT, MemReq_M=0 (request withdrawn): go to RUN, count=0.
  - WAIT, tmoRelease: go to RUN, set MemTimeout=1, count=0. Pipeline advances that cycle with FlushW=1, so the access becomes a bubble.
  - WAIT, otherwise: count+1; saturates, never wraps.
- Latency:
  - Detection is same-cycle combinational.
  - Counter and sticky flag update on the rising edge.
  - MemReady arriving in the same cycle as the request means no stall and no FSM transition.
- Sticky flag: MemTimeout clears only on `rst`.
- Reset mid-WAIT: returns to RUN next edge; no release cycle is generated.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three outputs: StallCnt[31:0], FlushCnt[31:0], TmoCnt[15:0].
  - StallCnt increments each cycle StallF=1.
  - FlushCnt increments each cycle FlushE=1 with rst=0.
  - TmoCnt increments per watchdog fire.
  - All three reset to 0 and saturate at all-ones.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Rd_M=5, RegWrite_M=1, Rd_W=5, RegWrite_W=1, Rs1_E=5, Rs2_E=0 -> ForwardA_E=10, ForwardB_E=00. Repeat with Rd_M=0 -> ForwardA_E=01.
- ResultSrc_E=01, Rd_E=7, Rs2_D=7 -> StallF=1, EnD=0, FlushE=1 for one cycle. Same with Rd_E=0 -> no stall.
- PCSrc_E=1 simultaneously with the load-use condition -> FlushD=FlushE=1, StallF=0, EnD=1.
- MemReq_M=1, MemReady=0 for 3 cycles, then 1 -> StallF=1, EnD=EnE=EnM=0, FlushW=1 for exactly 3 cycles, MemTimeout=0, FSM back in RUN.
- MEM_TIMEOUT=4, MemReady held 0 -> release on the 4th wait cycle, MemTimeout=1 thereafter. Assert rst -> MemTimeout=0 and all flushes=1 during reset.
- With HAZARD_PERF_EN: 2 load-use stalls + 1 branch -> StallCnt=2, FlushCnt=3.
